// File: rtl/icache_dm_pkg.sv
// icache_dm_pkg: shared widths, refill FSM state encoding and address-split helpers
package icache_dm_pkg;
   localparam int INST_ADDR_WIDTH    = 32;
   localparam int INST_DATA_WIDTH    = 32;
   localparam int ICACHE_STATE_WIDTH = 2;

   typedef enum logic [ICACHE_STATE_WIDTH-1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      FILL   = 2'd2
   } icache_state_t;

   function automatic int off_w(int line_words);
      return $clog2(line_words);
   endfunction

   function automatic int idx_w(int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(int addr_width, int line_words, int sets);
      return addr_width - 2 - $clog2(line_words) - $clog2(sets);
   endfunction
endpackage

// File: rtl/icache_dm_if.sv
// icache_dm_if: req/ack read bus between the cache (master) and external instruction memory (slave)
interface icache_dm_if
   import icache_dm_pkg::*;
#(
   parameter int ADDR_WIDTH = INST_ADDR_WIDTH,
   parameter int DATA_WIDTH = INST_DATA_WIDTH
);
   logic                  mem_req_out;
   logic [ADDR_WIDTH-1:0] mem_addr_out;
   logic [DATA_WIDTH-1:0] mem_data_in;
   logic                  mem_ack_in;

   modport master(output mem_req_out, mem_addr_out, input mem_data_in, mem_ack_in);
   modport slave(input mem_req_out, mem_addr_out, output mem_data_in, mem_ack_in);
endinterface

// File: rtl/icache_refill_fsm.sv
// icache_refill_fsm: fetches one whole line word by word into a line buffer, tracking
// whether a flush arrived mid-refill so the filled line is left invalid.
module icache_refill_fsm
   import icache_dm_pkg::*;
#(
   parameter int ADDR_WIDTH = INST_ADDR_WIDTH,
   parameter int DATA_WIDTH = INST_DATA_WIDTH,
   parameter int LINE_WORDS = 4,
   parameter int LINE_BITS  = ADDR_WIDTH - 2 - $clog2(LINE_WORDS)
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start,
   input  logic                                  flush_in,
   input  logic [LINE_BITS-1:0]                  start_line,
   output icache_state_t                         state,
   output logic                                  poison,
   output logic [LINE_BITS-1:0]                  line_id,
   output logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] line_buf,
   icache_dm_if.master                           mem
);
   localparam int OW = off_w(LINE_WORDS);
   localparam int LO = 2 + OW;

   logic [OW-1:0] cnt;
   logic          ack;
   logic          last;

   assign ack  = mem.mem_ack_in & mem.mem_req_out;
   assign last = cnt == OW'(LINE_WORDS - 1);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state            <= IDLE;
         cnt              <= '0;
         poison           <= 1'b0;
         line_id          <= '0;
         line_buf         <= '0;
         mem.mem_req_out  <= 1'b0;
         mem.mem_addr_out <= '0;
      end else
         case (state)
            IDLE:
               if (start) begin
                  state            <= REFILL;
                  cnt              <= '0;
                  poison           <= 1'b0;
                  line_id          <= start_line;
                  mem.mem_req_out  <= 1'b1;
                  mem.mem_addr_out <= {start_line, {LO{1'b0}}};
               end
            REFILL: begin
               if (flush_in) poison <= 1'b1;
               if (ack) begin
                  line_buf[cnt] <= mem.mem_data_in;
                  cnt           <= cnt + 1'b1;
                  // address stays on the last word after the final ack; req drops instead
                  if (last) begin
                     state           <= FILL;
                     mem.mem_req_out <= 1'b0;
                  end else
                     mem.mem_addr_out <= mem.mem_addr_out + ADDR_WIDTH'(4);
               end
            end
            default: state <= IDLE;
         endcase
endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache; hits answer combinationally,
// misses stall the core while icache_refill_fsm brings in the whole line.
module icache_dm
   import icache_dm_pkg::*;
#(
   parameter int ADDR_WIDTH = INST_ADDR_WIDTH,
   parameter int DATA_WIDTH = INST_DATA_WIDTH,
   parameter int LINE_WORDS = 4,
   parameter int SETS       = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] cpu_addr_in,
   input  logic                  cpu_en_in,
   input  logic                  flush_in,
   output logic [DATA_WIDTH-1:0] inst_out,
   output logic                  stall_req,
   icache_dm_if.master           mem
);
   localparam int OW = off_w(LINE_WORDS);
   localparam int IW = idx_w(SETS);
   localparam int TW = tag_w(ADDR_WIDTH, LINE_WORDS, SETS);
   localparam int LB = ADDR_WIDTH - 2 - OW;

   logic [SETS-1:0]                       valid;
   logic [TW-1:0]                         tags  [SETS];
   logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] lines [SETS];
   logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] line_buf;
   logic [LB-1:0]                         line_id;
   icache_state_t                         state;
   logic                                  poison;
   logic                                  hit;
   logic                                  unused;
   logic [IW-1:0]                         idx;
   logic [OW-1:0]                         off;
   logic [TW-1:0]                         tag;

   assign idx    = cpu_addr_in[2+OW +: IW];
   assign off    = cpu_addr_in[2 +: OW];
   assign tag    = cpu_addr_in[ADDR_WIDTH-1 -: TW];
   assign unused = ^cpu_addr_in[1:0];
   assign hit    = cpu_en_in && valid[idx] && tags[idx] == tag;

   assign inst_out  = hit ? lines[idx][off] : '0;
   assign stall_req = (state != IDLE) || (cpu_en_in && !hit);

   icache_refill_fsm #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .LINE_WORDS(LINE_WORDS)
   ) u_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (state == IDLE && cpu_en_in && !hit),
      .flush_in  (flush_in),
      .start_line(cpu_addr_in[ADDR_WIDTH-1:2+OW]),
      .state     (state),
      .poison    (poison),
      .line_id   (line_id),
      .line_buf  (line_buf),
      .mem       (mem)
   );

   // flush wins over the FILL valid-set
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) valid <= '0;
      else if (flush_in) valid <= '0;
      else if (state == FILL && !poison) valid[line_id[IW-1:0]] <= 1'b1;

   always_ff @(posedge clk)
      if (state == FILL) begin
         lines[line_id[IW-1:0]] <= line_buf;
         tags[line_id[IW-1:0]]  <= line_id[IW +: TW];
      end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed fetch sequence against a req/ack memory model, expected
// instructions queued at issue and compared when the stall clears.
module tb_icache_dm;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic        cpu_en = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] inst;
   logic        stall;
   logic        spur = 1'b0;
   int          n_vec = 0;
   int          n_err = 0;
   int          delay = 0;
   int          wcnt = 0;
   int          req_cycles = 0;
   logic [31:0] exp_q[$];
   logic [31:0] alog[$];
   logic        prev_req = 1'b0;
   logic        prev_ack = 1'b0;
   logic [31:0] prev_addr = '0;

   icache_dm_if mif ();

   icache_dm dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_addr_in(cpu_addr),
      .cpu_en_in  (cpu_en),
      .flush_in   (flush),
      .inst_out   (inst),
      .stall_req  (stall),
      .mem        (mif)
   );

   always #5 clk = ~clk;

   assign mif.mem_ack_in  = spur | (mif.mem_req_out && wcnt >= delay);
   assign mif.mem_data_in = 32'h1000_0000 | mif.mem_addr_out;

   always @(posedge clk) wcnt <= (mif.mem_req_out && !mif.mem_ack_in) ? wcnt + 1 : 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && prev_req && !prev_ack && mif.mem_req_out)
         chk("addr_hold", mif.mem_addr_out, prev_addr);
      if (mif.mem_req_out) req_cycles++;
      if (mif.mem_req_out && mif.mem_ack_in) alog.push_back(mif.mem_addr_out);
      prev_req  <= rst_n && mif.mem_req_out;
      prev_ack  <= mif.mem_ack_in;
      prev_addr <= mif.mem_addr_out;
   end

   task automatic fetch(input logic [31:0] a, input int exp_stall);
      int n = 0;
      logic [31:0] e;
      cpu_addr = a;
      cpu_en   = 1'b1;
      exp_q.push_back(32'h1000_0000 | a);
      @(negedge clk);
      while (stall && n < 200) begin
         n++;
         @(negedge clk);
      end
      e = exp_q.pop_front();
      chk($sformatf("inst@%h", a), inst, e);
      chk($sformatf("stall_cycles@%h", a), 32'(n), 32'(exp_stall));
      @(posedge clk);
      #1;
   endtask

   task automatic chk_log(input int start, input logic [31:0] base);
      for (int i = 0; i < 4; i++)
         chk($sformatf("mem_addr[%0d]", i), alog[start+i], base + 32'(4 * i));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int rc;
      int lb;
      repeat (2) @(negedge clk);
      chk("rst_stall", {31'b0, stall}, 0);
      chk("rst_inst", inst, 0);
      chk("rst_req", {31'b0, mif.mem_req_out}, 0);
      chk("rst_maddr", mif.mem_addr_out, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      fetch(32'h0, 6);
      chk("refill0_acks", 32'(alog.size()), 4);
      chk_log(0, 32'h0);

      rc = req_cycles;
      fetch(32'h4, 0);
      fetch(32'h8, 0);
      fetch(32'hC, 0);
      chk("hit_no_req", 32'(req_cycles), 32'(rc));

      fetch(32'h100, 6);
      fetch(32'h0, 6);

      lb = alog.size();
      delay = 3;
      fetch(32'h208, 18);
      chk("slow_acks", 32'(alog.size() - lb), 4);
      chk_log(lb, 32'h200);
      delay = 0;
      fetch(32'h204, 0);

      lb = alog.size();
      fork
         fetch(32'h40, 12);
         begin
            for (int i = 0; i < 50 && !mif.mem_req_out; i++) @(negedge clk);
            @(posedge clk);
            #1 flush = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
         end
      join
      chk("flush_acks", 32'(alog.size() - lb), 8);
      chk_log(lb, 32'h40);
      chk_log(lb + 4, 32'h40);
      fetch(32'h44, 0);

      rc = req_cycles;
      cpu_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cpu_addr = $urandom;
         @(negedge clk);
         chk("dis_inst", inst, 0);
         chk("dis_stall", {31'b0, stall}, 0);
         @(posedge clk);
         #1;
      end
      spur = 1'b1;
      @(posedge clk);
      #1 spur = 1'b0;
      @(negedge clk);
      chk("spur_req", {31'b0, mif.mem_req_out}, 0);
      chk("spur_stall", {31'b0, stall}, 0);
      chk("dis_no_req", 32'(req_cycles), 32'(rc));
      @(posedge clk);
      #1;
      fetch(32'h48, 0);

      cpu_addr = 32'h300;
      cpu_en   = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      chk("pre_rst_req", {31'b0, mif.mem_req_out}, 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_req", {31'b0, mif.mem_req_out}, 0);
      chk("async_rst_maddr", mif.mem_addr_out, 0);
      cpu_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      fetch(32'h4C, 6);
      fetch(32'h300, 6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
